morse_decoder: RTL and testbench

- Receive-side stage that consumes the serial Morse stream produced by the letter encoder: DotDashOut drives BitIn and NewBitOut drives BitValid.
- Measures mark/space run lengths in bit-units, assembles dot/dash symbols and matches them against the 8-letter table (A–H, codes 0–7).
- Returns the 3-bit letter code with a one-cycle valid strobe, or flags a malformed sequence.
- Used for loopback self-check of the encoder and as a receive path driven from a switch/key.

---
 rtl/morse_decoder.sv | 160 ++++++++++++++++
 tb/tb_morse_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_decoder.sv
// Morse receive stage: times mark/space runs of a strobed bit stream, builds the
// dot/dash pattern of one letter and looks it up in the A-H table (codes 0-7).
module morse_decoder #(
  parameter int DASH_UNITS  = 3,
  parameter int GAP_UNITS   = 3,
  parameter int MAX_SYMBOLS = 4
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       BitValid,
  input  logic       BitIn,
  input  logic       Clear,
  output logic [2:0] Letter,
  output logic       LetterValid,
  output logic       Error,
  output logic       Busy
);

  localparam int PW = (MAX_SYMBOLS > 4) ? MAX_SYMBOLS : 4;
  localparam int CW = $clog2(MAX_SYMBOLS + 1);
  localparam int GW = $clog2(GAP_UNITS + 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, RESYNC} state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] code;
  } match_t;

  state_t        state;
  logic [2:0]    run;
  logic [GW-1:0] gap;
  logic [PW-1:0] pattern;
  logic [CW-1:0] count;

  // Pattern is shifted in from the LSB, so the first symbol ends up in the
  // highest occupied bit; unused upper bits are always zero.
  function automatic match_t lookup(input logic [CW-1:0] cnt, input logic [PW-1:0] pat);
    match_t m;
    m.hit  = 1'b1;
    m.code = 3'd0;
    if      (cnt == CW'(2) && pat == PW'(4'b0001)) m.code = 3'd0;
    else if (cnt == CW'(4) && pat == PW'(4'b1000)) m.code = 3'd1;
    else if (cnt == CW'(4) && pat == PW'(4'b1010)) m.code = 3'd2;
    else if (cnt == CW'(3) && pat == PW'(4'b0100)) m.code = 3'd3;
    else if (cnt == CW'(1) && pat == PW'(4'b0000)) m.code = 3'd4;
    else if (cnt == CW'(4) && pat == PW'(4'b0010)) m.code = 3'd5;
    else if (cnt == CW'(3) && pat == PW'(4'b0110)) m.code = 3'd6;
    else if (cnt == CW'(4) && pat == PW'(4'b0000)) m.code = 3'd7;
    else m.hit = 1'b0;
    return m;
  endfunction

  logic   is_dot, is_dash, sym_full, gap_done;
  match_t match;

  assign is_dot   = (run == 3'd1);
  assign is_dash  = (run == 3'(DASH_UNITS));
  assign sym_full = (count == CW'(MAX_SYMBOLS));
  // the strobe currently being sampled is the GAP_UNITS-th zero
  assign gap_done = (gap >= GW'(GAP_UNITS - 1));
  assign match    = lookup(count, pattern);
  assign Busy     = (state != IDLE);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      run         <= '0;
      gap         <= '0;
      pattern     <= '0;
      count       <= '0;
      Letter      <= 3'd0;
      LetterValid <= 1'b0;
      Error       <= 1'b0;
    end else begin
      LetterValid <= 1'b0;
      Error       <= 1'b0;
      if (Clear) begin
        state   <= IDLE;
        run     <= '0;
        gap     <= '0;
        pattern <= '0;
        count   <= '0;
      end else if (BitValid) begin
        case (state)
          IDLE: begin
            if (BitIn) begin
              state <= MARK;
              run   <= 3'd1;
            end
          end

          MARK: begin
            if (BitIn) begin
              if (run != 3'd7) run <= run + 3'd1;
            end else if ((is_dot || is_dash) && !sym_full) begin
              pattern <= {pattern[PW-2:0], is_dash};
              count   <= count + CW'(1);
              run     <= '0;
              gap     <= GW'(1);
              state   <= SPACE;
            end else begin
              Error   <= 1'b1;
              run     <= '0;
              gap     <= '0;
              pattern <= '0;
              count   <= '0;
              state   <= RESYNC;
            end
          end

          SPACE: begin
            if (!BitIn) begin
              if (gap_done) begin
                // letter gap already seen: a miss goes straight to IDLE
                if (match.hit) begin
                  Letter      <= match.code;
                  LetterValid <= 1'b1;
                end else begin
                  Error <= 1'b1;
                end
                gap     <= '0;
                pattern <= '0;
                count   <= '0;
                state   <= IDLE;
              end else begin
                gap <= gap + GW'(1);
              end
            end else if (gap == GW'(1)) begin
              state <= MARK;
              run   <= 3'd1;
              gap   <= '0;
            end else begin
              Error   <= 1'b1;
              gap     <= '0;
              pattern <= '0;
              count   <= '0;
              state   <= RESYNC;
            end
          end

          RESYNC: begin
            if (BitIn) begin
              gap <= '0;
            end else if (gap_done) begin
              gap   <= '0;
              state <= IDLE;
            end else begin
              gap <= gap + GW'(1);
            end
          end
        endcase
      end
    end
  end

  a_pulse_excl: assert property (@(posedge Clock) disable iff (!Reset_n) !(LetterValid && Error));
  a_count_max:  assert property (@(posedge Clock) disable iff (!Reset_n) count <= CW'(MAX_SYMBOLS));

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: table of strobed bit sequences with expected pulses
// queued per strobe, plus hand-written Clear and mid-mark reset sequences.
module tb_morse_decoder;

  localparam int EV_NONE = 0;
  localparam int EV_LET  = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    logic       b;
    int         ev;
    logic [2:0] code;
    int         space;
    logic       last;
  } vec_t;

  typedef struct {
    int         kind;
    logic [2:0] letter;
    int         due;
  } exp_t;

  logic       Clock, Reset_n, BitValid, BitIn, Clear;
  logic [2:0] Letter;
  logic       LetterValid, Error, Busy;

  vec_t       vecs[$];
  exp_t       exp_q[$];
  logic [2:0] exp_letter;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  morse_decoder dut (
    .Clock(Clock), .Reset_n(Reset_n), .BitValid(BitValid), .BitIn(BitIn),
    .Clear(Clear), .Letter(Letter), .LetterValid(LetterValid), .Error(Error),
    .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Every pulse must match the head of the queue, on the cycle it is due.
  always @(negedge Clock) begin
    exp_t e;
    if (Reset_n) begin
      if (LetterValid || Error) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: LetterValid=%0b Error=%0b Letter=%0d cycle=%0d, no pulse required",
                   LetterValid, Error, Letter, cyc);
        end else begin
          e = exp_q.pop_front();
          if ((LetterValid && Error) || e.kind != (LetterValid ? EV_LET : EV_ERR) ||
              e.due != cyc || Letter !== e.letter) begin
            n_fail++;
            $display("FAIL pulse_check: got kind=%0d letter=%0d cycle=%0d, required kind=%0d letter=%0d cycle=%0d",
                     LetterValid ? EV_LET : EV_ERR, Letter, cyc, e.kind, e.letter, e.due);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_pulse: got none at cycle %0d, required kind=%0d letter=%0d",
                 cyc, e.kind, e.letter);
      end
    end
  end

  task automatic add_seq(input logic [31:0] bits, input int n, input int ev_idx, input int ev,
                         input logic [2:0] code, input int space);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.b     = bits[n-1-i];
      v.ev    = (i == ev_idx) ? ev : EV_NONE;
      v.code  = code;
      v.space = space;
      v.last  = (i == n - 1);
      vecs.push_back(v);
    end
  endtask

  task automatic strobe(input logic b, input int ev, input logic [2:0] code);
    exp_t e;
    @(negedge Clock);
    BitValid = 1'b1;
    BitIn    = b;
    if (ev == EV_LET) exp_letter = code;
    if (ev != EV_NONE) begin
      e.kind   = ev;
      e.letter = exp_letter;
      e.due    = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  // non-strobe cycles carry random BitIn, which must be ignored
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clock);
      BitValid = 1'b0;
      BitIn    = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    Reset_n    = 1'b0;
    BitValid   = 1'b0;
    BitIn      = 1'b0;
    Clear      = 1'b0;
    exp_letter = 3'd0;

    //        bits        n   idx  event   code  space
    add_seq(32'hB8,       8,  7,  EV_LET, 3'd0, 3); // A, strobe every 4th cycle
    add_seq(32'h800,     12,  3,  EV_LET, 3'd4, 0); // E, encoder zero tail
    add_seq(32'hAA0,     12,  9,  EV_LET, 3'd7, 0); // H
    add_seq(32'hD8,       8,  2,  EV_ERR, 3'd0, 0); // 2-unit mark, resync over 1s
    add_seq(32'hB8,       8,  7,  EV_LET, 3'd0, 0); // A after resync
    add_seq(32'h1550,    13,  9,  EV_ERR, 3'd0, 0); // five dots: overflow
    add_seq(32'hEA8,     12, 11,  EV_LET, 3'd1, 1); // B, BitIn toggling between strobes
    add_seq(32'h3B8,     10,  9,  EV_ERR, 3'd0, 0); // 2:11 table miss
    add_seq(32'h3AE8,    14, 13,  EV_LET, 3'd2, 0); // C
    add_seq(32'h3A8,     10,  9,  EV_LET, 3'd3, 0); // D
    add_seq(32'hAE8,     12, 11,  EV_LET, 3'd5, 0); // F
    add_seq(32'h48,       7,  3,  EV_ERR, 3'd0, 0); // 1 after 2-unit gap
    add_seq(32'h1FF0,    13,  9,  EV_ERR, 3'd0, 0); // 9-unit mark, saturated run
    add_seq(32'hEE8,     12, 11,  EV_LET, 3'd6, 2); // G

    repeat (2) @(negedge Clock);
    chk("reset_letter", 32'(Letter), 32'd0);
    chk("reset_letter_valid", 32'(LetterValid), 32'd0);
    chk("reset_error", 32'(Error), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    Reset_n = 1'b1;
    idle(2);

    for (int i = 0; i < vecs.size(); i++) begin
      strobe(vecs[i].b, vecs[i].ev, vecs[i].code);
      if (vecs[i].last) begin
        idle(1);
        chk($sformatf("busy_after_seq%0d", i), 32'(Busy), 32'd0);
        chk($sformatf("letter_after_seq%0d", i), 32'(Letter), 32'(exp_letter));
      end
      idle(vecs[i].space);
    end

    // Clear mid-letter (dot stored, mark running) wins over a same-cycle strobe
    strobe(1'b1, EV_NONE, 3'd0);
    strobe(1'b0, EV_NONE, 3'd0);
    strobe(1'b1, EV_NONE, 3'd0);
    strobe(1'b1, EV_NONE, 3'd0);
    @(negedge Clock);
    BitValid = 1'b1;
    BitIn    = 1'b0;
    Clear    = 1'b1;
    @(negedge Clock);
    BitValid = 1'b0;
    Clear    = 1'b0;
    chk("clear_busy", 32'(Busy), 32'd0);
    chk("clear_letter_held", 32'(Letter), 32'(exp_letter));
    strobe(1'b1, EV_NONE, 3'd0);
    strobe(1'b0, EV_NONE, 3'd0);
    strobe(1'b0, EV_NONE, 3'd0);
    strobe(1'b0, EV_LET, 3'd4);
    idle(2);
    chk("clear_then_e", 32'(Letter), 32'd4);

    // async reset mid-mark, with a dot already stored
    strobe(1'b1, EV_NONE, 3'd0);
    strobe(1'b0, EV_NONE, 3'd0);
    strobe(1'b1, EV_NONE, 3'd0);
    idle(1);
    chk("busy_mid_mark", 32'(Busy), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_letter", 32'(Letter), 32'd0);
    chk("rst_letter_valid", 32'(LetterValid), 32'd0);
    exp_letter = 3'd0;
    @(negedge Clock);
    Reset_n = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a_bits;
      a_bits = 8'hB8;
      strobe(a_bits[7-i], (i == 7) ? EV_LET : EV_NONE, 3'd0);
    end
    idle(2);
    chk("rst_then_a_busy", 32'(Busy), 32'd0);
    chk("rst_then_a_letter", 32'(Letter), 32'd0);

    idle(5);
    chk("pending_pulses", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
